// File: rtl/dm_arb_pkg.sv
// Shared widths and FSM state encoding for the data-memory arbiter.
// Pure definitions; no logic, no latency.
package dm_arb_pkg;
  localparam int ADDR_W_DEF       = 4;
  localparam int DATA_W_DEF       = 4;
  localparam int STARVE_LIMIT_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'b00,
    ST_DBG_ACCESS = 2'b01,
    ST_DBG_RDATA  = 2'b10
  } arb_state_e;
endpackage

// File: rtl/data_mem_arbiter_if.sv
// CPU / debug / memory-macro signal bundle around the data-memory arbiter.
// slave = arbiter side, master = surrounding CPU, debug port and memory.
interface data_mem_arbiter_if
  import dm_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic              cpu_access;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_we;
  logic              cpu_stall;
  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_gnt;
  logic [DATA_W-1:0] dbg_rdata;
  logic              dbg_rvalid;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_wren;
  logic [DATA_W-1:0] mem_q;
  logic [1:0]        arb_state;

  modport slave (
    input  cpu_access, cpu_addr, cpu_wdata, cpu_we,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata, mem_q,
    output cpu_stall, dbg_gnt, dbg_rdata, dbg_rvalid,
    output mem_addr, mem_wdata, mem_wren, arb_state
  );

  modport master (
    output cpu_access, cpu_addr, cpu_wdata, cpu_we,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata, mem_q,
    input  cpu_stall, dbg_gnt, dbg_rdata, dbg_rvalid,
    input  mem_addr, mem_wdata, mem_wren, arb_state
  );
endinterface

// File: rtl/starve_counter.sv
// Saturating count of denied debug-request cycles; clear wins over increment.
// at_limit is combinational from the count register.
module starve_counter #(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);
  localparam int            CW  = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(LIMIT);

  logic [CW-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != LIM)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_limit = (cnt_q == LIM);
endmodule

// File: rtl/data_mem_arbiter.sv
// Shares the data memory between CPU (priority) and a debug port; a debug slot is one
// cycle, forced by a one-cycle cpu_stall after STARVE_LIMIT denied cycles; read data two cycles after grant.
module data_mem_arbiter
  import dm_arb_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input logic                clk,
  input logic                reset,
  data_mem_arbiter_if.slave  bus
);
  arb_state_e        state_d, state_q;
  logic [DATA_W-1:0] rdata_d, rdata_q;
  logic              rvalid_d, rvalid_q;
  logic              cnt_inc, cnt_clr, at_limit;
  logic              gnt;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_d;
  logic              mem_wren_d;

  starve_counter #(.LIMIT(STARVE_LIMIT)) u_starve (
    .clk      (clk),
    .reset    (reset),
    .inc      (cnt_inc),
    .clr      (cnt_clr),
    .at_limit (at_limit)
  );

  always_comb begin
    state_d  = ST_IDLE;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    cnt_inc  = 1'b0;
    cnt_clr  = 1'b0;
    gnt      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.dbg_req && (!bus.cpu_access || at_limit)) begin
          state_d = ST_DBG_ACCESS;
        end else if (bus.dbg_req) begin
          cnt_inc = 1'b1;
        end else begin
          cnt_clr = 1'b1;
        end
      end
      ST_DBG_ACCESS: begin
        gnt     = 1'b1;
        cnt_clr = 1'b1;
        state_d = bus.dbg_we ? ST_IDLE : ST_DBG_RDATA;
      end
      ST_DBG_RDATA: begin
        // Memory already serves the CPU again; mem_q still holds the debug read.
        rdata_d  = bus.mem_q;
        rvalid_d = 1'b1;
        state_d  = ST_IDLE;
      end
      default: begin
        cnt_clr = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    mem_addr_d  = bus.cpu_addr;
    mem_wdata_d = bus.cpu_wdata;
    mem_wren_d  = bus.cpu_we;
    if (gnt) begin
      mem_addr_d  = bus.dbg_addr;
      mem_wdata_d = bus.dbg_wdata;
      mem_wren_d  = bus.dbg_we;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign bus.mem_addr   = mem_addr_d;
  assign bus.mem_wdata  = mem_wdata_d;
  assign bus.mem_wren   = mem_wren_d;
  assign bus.dbg_gnt    = gnt;
  assign bus.cpu_stall  = gnt;
  assign bus.dbg_rdata  = rdata_q;
  assign bus.dbg_rvalid = rvalid_q;
  assign bus.arb_state  = state_q;
endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: directed scenarios plus random traffic, every cycle
// compared against a transaction-level model of the arbitration rules and the memory.
module tb_data_mem_arbiter;
  localparam int AW    = 4;
  localparam int DW    = 4;
  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic reset;
  logic mem_clr;
  always #5 clk = ~clk;

  data_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  data_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Memory macro: synchronous write, registered read data one cycle after the address.
  logic [DW-1:0] mem [16];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 16; i++) mem[i] <= '0;
      bus.mem_q <= '0;
    end else begin
      if (bus.mem_wren) mem[bus.mem_addr] <= bus.mem_wdata;
      bus.mem_q <= mem[bus.mem_addr];
    end
  end

  int total = 0;
  int bad   = 0;

  // Reference model: "this cycle is a grant", "this cycle returns read data", etc.
  bit            m_gnt, m_ret, m_rv;
  int            m_wait;
  logic [DW-1:0] m_rdata, m_pend;
  logic [DW-1:0] ref_mem [16];

  logic          obs_gnt, obs_stall, obs_wren, obs_rv;
  logic [DW-1:0] obs_rdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_gnt = 0; m_ret = 0; m_rv = 0; m_wait = 0; m_rdata = '0; m_pend = '0;
  endtask

  task automatic model_step();
    bit n_gnt, n_ret, n_rv;
    n_gnt = 0; n_ret = 0; n_rv = 0;
    if (m_gnt) begin
      if (bus.dbg_we) ref_mem[bus.dbg_addr] = bus.dbg_wdata;
      else begin
        m_pend = ref_mem[bus.dbg_addr];
        n_ret  = 1;
      end
      m_wait = 0;
    end else begin
      if (bus.cpu_we) ref_mem[bus.cpu_addr] = bus.cpu_wdata;
      if (m_ret) begin
        n_rv    = 1;
        m_rdata = m_pend;
      end else if (bus.dbg_req) begin
        if (!bus.cpu_access || m_wait == LIMIT) n_gnt = 1;
        else if (m_wait < LIMIT) m_wait++;
      end else begin
        m_wait = 0;
      end
    end
    m_gnt = n_gnt; m_ret = n_ret; m_rv = n_rv;
  endtask

  task automatic drive(input bit acc, input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                       input bit cwe, input bit req, input bit dwe,
                       input logic [AW-1:0] da, input logic [DW-1:0] dd);
    bus.cpu_access = acc; bus.cpu_addr = ca; bus.cpu_wdata = cd; bus.cpu_we = cwe;
    bus.dbg_req = req; bus.dbg_we = dwe; bus.dbg_addr = da; bus.dbg_wdata = dd;
  endtask

  // One clock: check at the falling edge, advance the model at the rising edge.
  task automatic cycle();
    @(negedge clk);
    obs_gnt = bus.dbg_gnt; obs_stall = bus.cpu_stall; obs_wren = bus.mem_wren;
    obs_rv = bus.dbg_rvalid; obs_rdata = bus.dbg_rdata;
    chk("gnt", bus.dbg_gnt, m_gnt);
    chk("stall", bus.cpu_stall, m_gnt);
    chk("state", bus.arb_state, m_gnt ? 32'd1 : (m_ret ? 32'd2 : 32'd0));
    chk("mem_addr", bus.mem_addr, m_gnt ? bus.dbg_addr : bus.cpu_addr);
    chk("mem_wdata", bus.mem_wdata, m_gnt ? bus.dbg_wdata : bus.cpu_wdata);
    chk("mem_wren", bus.mem_wren, m_gnt ? bus.dbg_we : bus.cpu_we);
    chk("rvalid", bus.dbg_rvalid, m_rv);
    chk("rdata", bus.dbg_rdata, m_rdata);
    @(posedge clk);
    if (!reset) begin
      if (bus.cpu_we) ref_mem[bus.cpu_addr] = bus.cpu_wdata;
      model_reset();
    end else begin
      model_step();
    end
    #1;
  endtask

  initial begin
    int gk, stalls, b2b;
    bit prev, seen;

    reset = 1'b0;
    mem_clr = 1'b1;
    drive(1, 4'h5, 4'h6, 0, 0, 0, 4'h0, 4'h0);
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    model_reset();
    #1;
    chk("rst_state", bus.arb_state, 0);
    chk("rst_gnt", bus.dbg_gnt, 0);
    chk("rst_stall", bus.cpu_stall, 0);
    chk("rst_rvalid", bus.dbg_rvalid, 0);
    chk("rst_rdata", bus.dbg_rdata, 0);
    chk("rst_mem_addr", bus.mem_addr, 4'h5);
    repeat (2) @(posedge clk);
    #1;
    mem_clr = 1'b0;
    reset = 1'b1;

    // Idle CPU: debug write 3<-A, then debug read of 3.
    drive(0, 4'h0, 4'h0, 0, 1, 1, 4'h3, 4'hA);
    cycle();
    chk("wr_pre_gnt", obs_gnt, 0);
    cycle();
    chk("wr_gnt", obs_gnt, 1);
    chk("wr_wren", obs_wren, 1);
    drive(0, 4'h0, 4'h0, 0, 1, 0, 4'h3, 4'h0);
    cycle();
    chk("rd_pre_gnt", obs_gnt, 0);
    chk("rd_pre_wren", obs_wren, 0);
    cycle();
    chk("rd_gnt", obs_gnt, 1);
    chk("rd_gnt_wren", obs_wren, 0);
    drive(0, 4'h0, 4'h0, 0, 0, 0, 4'h0, 4'h0);
    cycle();
    chk("rd_g1_rvalid", obs_rv, 0);
    cycle();
    chk("rd_g2_rvalid", obs_rv, 1);
    chk("rd_g2_rdata", obs_rdata, 4'hA);
    cycle();

    // Starvation: CPU writes 7<-5 every cycle while a debug read of 7 waits.
    drive(1, 4'h7, 4'h5, 1, 1, 0, 4'h7, 4'h0);
    gk = -1; stalls = 0;
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (obs_gnt) begin gk = k; break; end
      stalls += int'(obs_stall);
    end
    chk("starve_gnt_cycle", gk, LIMIT + 1);
    chk("starve_early_stall", stalls, 0);
    chk("starve_gnt_stall", obs_stall, 1);
    chk("starve_cpu_wr_blocked", obs_wren, 0);
    bus.dbg_req = 1'b0;
    cycle();
    cycle();
    chk("starve_rvalid", obs_rv, 1);
    chk("starve_rdata", obs_rdata, 4'h5);
    drive(0, 4'h0, 4'h0, 0, 0, 0, 4'h0, 4'h0);
    repeat (2) cycle();

    // Continuous debug reads with idle CPU: grants every third cycle, never back-to-back.
    drive(0, 4'h1, 4'h0, 0, 1, 0, 4'h3, 4'h0);
    stalls = 0; b2b = 0; prev = 0;
    for (int k = 0; k < 24; k++) begin
      cycle();
      stalls += int'(obs_stall);
      if (prev && obs_gnt) b2b++;
      prev = obs_gnt;
    end
    chk("held_b2b", b2b, 0);
    chk("held_stalls", stalls, 8);
    chk("held_duty", (stalls * 2 <= 24), 1);
    drive(0, 4'h0, 4'h0, 0, 0, 0, 4'h0, 4'h0);
    repeat (3) cycle();

    // Short request under a busy CPU, dropped: no grant, and the wait restarts from zero.
    drive(1, 4'h2, 4'h0, 0, 1, 0, 4'h4, 4'h0);
    stalls = 0;
    repeat (2) begin cycle(); stalls += int'(obs_stall); end
    bus.dbg_req = 1'b0;
    repeat (3) begin cycle(); stalls += int'(obs_stall); end
    chk("pulse_no_stall", stalls, 0);
    bus.dbg_req = 1'b1;
    gk = -1;
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (obs_gnt) begin gk = k; break; end
    end
    chk("pulse_cnt_cleared", gk, LIMIT + 1);
    drive(0, 4'h0, 4'h0, 0, 0, 0, 4'h0, 4'h0);
    repeat (3) cycle();

    // Random traffic; a debug request is held until granted.
    for (int i = 0; i < 300; i++) begin
      bus.cpu_access = ($urandom_range(0, 3) != 0);
      bus.cpu_we     = bus.cpu_access && $urandom_range(0, 1) == 1;
      bus.cpu_addr   = AW'($urandom);
      bus.cpu_wdata  = DW'($urandom);
      if (!bus.dbg_req || obs_gnt) begin
        bus.dbg_req   = ($urandom_range(0, 2) == 0);
        bus.dbg_we    = $urandom_range(0, 1) == 1;
        bus.dbg_addr  = AW'($urandom);
        bus.dbg_wdata = DW'($urandom);
      end
      cycle();
    end
    drive(0, 4'h0, 4'h0, 0, 0, 0, 4'h0, 4'h0);
    repeat (4) cycle();

    // Reset while a debug read is returning data.
    drive(0, 4'h9, 4'h0, 0, 1, 0, 4'h3, 4'h0);
    cycle();
    cycle();
    chk("rstrd_gnt", obs_gnt, 1);
    bus.dbg_req = 1'b0;
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    chk("rstrd_state", bus.arb_state, 0);
    chk("rstrd_rvalid", bus.dbg_rvalid, 0);
    chk("rstrd_rdata", bus.dbg_rdata, 0);
    chk("rstrd_mem_addr", bus.mem_addr, 4'h9);
    cycle();
    reset = 1'b1;
    seen = 0;
    repeat (3) begin cycle(); seen |= obs_rv; end
    chk("rstrd_no_rvalid", seen, 0);

    for (int i = 0; i < 16; i++) chk($sformatf("mem[%0d]", i), mem[i], ref_mem[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
